rvb_bitcnt_dispatch: RTL

RVB_BITCNT_DISPATCH -- requirements
Module: rvb_bitcnt_dispatch

---
 rtl/rvb_bitcnt_dispatch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rvb_bitcnt_dispatch.sv
// Decode and dispatch for the bit-count op group: legality check, a 2-entry
// in-order FIFO, and head presentation to either the bit-count unit or the illegal-op port.
module rvb_bitcnt_dispatch #(
  parameter int unsigned XLEN = 64,
  parameter bit          BMAT = 1'b0
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [4:0]      in_tag,
  output logic            bc_valid,
  input  logic            bc_ready,
  output logic [XLEN-1:0] bc_rs1,
  output logic            bc_insn3,
  output logic            bc_insn20,
  output logic            bc_insn21,
  output logic            bc_insn22,
  output logic [4:0]      bc_tag,
  output logic            ill_valid,
  input  logic            ill_ready,
  output logic [4:0]      ill_tag,
  output logic [15:0]     ill_count
);

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic            insn3;
    logic            insn20;
    logic            insn21;
    logic            insn22;
    logic [4:0]      tag;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;

  occ_e        occ_q, occ_d;
  entry_t      e0_q, e0_d, e1_q, e1_d;
  logic [15:0] cnt_q, cnt_d;
  entry_t      new_entry;
  logic        legal, push, pop, head_valid;
  logic        unused_insn;

  assign unused_insn = ^{in_insn[19:15], in_insn[11:7]};

  always_comb begin
    logic       enc_ok, op_imm, op_imm32;
    logic [4:0] sel;
    enc_ok   = (in_insn[31:25] == 7'b0110000) && (in_insn[14:12] == 3'b001);
    op_imm   = (in_insn[6:0] == 7'b0010011);
    op_imm32 = (in_insn[6:0] == 7'b0011011) && (XLEN == 64);
    sel      = in_insn[24:20];
    legal = enc_ok && (
              ((op_imm || op_imm32) && (sel == 5'd0 || sel == 5'd1 || sel == 5'd2)) ||
              (op_imm && (sel == 5'd4 || sel == 5'd5)) ||
              (op_imm && (XLEN == 64) && BMAT && (sel == 5'd3)));
    new_entry        = '0;
    new_entry.rs1    = in_rs1;
    new_entry.insn3  = in_insn[3];
    new_entry.insn20 = in_insn[20];
    new_entry.insn21 = in_insn[21];
    new_entry.insn22 = in_insn[22];
    new_entry.tag    = in_tag;
    new_entry.ill    = ~legal;
  end

  // A full FIFO refuses pushes regardless of a same-cycle pop, so in_ready never looks at the sinks.
  assign in_ready   = resetn && (occ_q != OCC_TWO);
  assign push       = in_valid && in_ready;
  assign head_valid = (occ_q != OCC_EMPTY);
  assign pop        = head_valid && (e0_q.ill ? ill_ready : bc_ready);

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      occ_q <= OCC_EMPTY;
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    occ_d = occ_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case (occ_q)
      OCC_EMPTY: if (push) begin
        occ_d = OCC_ONE;
        e0_d  = new_entry;
      end
      OCC_ONE: begin
        if (push && pop) e0_d = new_entry;
        else if (push) begin
          occ_d = OCC_TWO;
          e1_d  = new_entry;
        end else if (pop) occ_d = OCC_EMPTY;
      end
      OCC_TWO: if (pop) begin
        occ_d = OCC_ONE;
        e0_d  = e1_q;
      end
      default: occ_d = OCC_EMPTY;
    endcase
    if (pop && e0_q.ill && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Outputs: head registers gated so idle data reads as zero
  always_comb begin
    bc_valid  = head_valid && !e0_q.ill;
    ill_valid = head_valid && e0_q.ill;
    bc_rs1    = bc_valid ? e0_q.rs1 : '0;
    bc_insn3  = bc_valid && e0_q.insn3;
    bc_insn20 = bc_valid && e0_q.insn20;
    bc_insn21 = bc_valid && e0_q.insn21;
    bc_insn22 = bc_valid && e0_q.insn22;
    bc_tag    = bc_valid ? e0_q.tag : '0;
    ill_tag   = ill_valid ? e0_q.tag : '0;
    ill_count = cnt_q;
  end

endmodule
